mem_port_initiator: RTL and testbench

MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

---
 rtl/mem_port_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_initiator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_initiator.sv
// mem_port_initiator
//   Single-port memory request initiator. Client commands are accepted on a
//   valid/ready handshake, registered onto the memory port (one-cycle latency)
//   and held stable while the memory freezes. Responses return in order, one
//   per consumed request. A 1-bit type FIFO tells reads from writes. Read data
//   is queued in a response FIFO toward the client, and write responses are
//   dropped. Credits (outstanding + queued responses) bound acceptance to DEPTH.
//
//   Optional feature macro: MEM_INIT_ERR_EN
//     defined   -> a response arriving with nothing outstanding sets the sticky
//                  err_unexpected flag, which only reset clears.
//     undefined -> err_unexpected is tied low.
//     In both builds a stray response is ignored.
//
//   Ports
//     clk, reset_n                 clock, synchronous active-low reset
//     cmd_valid/ready/addr/wdata/wen   client request channel
//     drain                        stop accepting, retire everything outstanding
//     mem_valid/addr/data/wen      registered request toward memory
//     mem_freeze                   memory backpressure
//     mem_rvalid/rdata             in-order memory responses
//     rsp_valid/ready/data         read data toward client
//     busy                         state machine not idle
//     err_unexpected               sticky stray-response flag
module mem_port_initiator #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_wen,
  input  logic              drain,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wen,
  output logic              mem_valid,
  input  logic              mem_freeze,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err_unexpected
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_STALL,
    ST_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_outs;
  logic [CNT_W-1:0]  r_rsp_cnt;
  logic [DEPTH-1:0]  r_typ;
  logic [PTR_W-1:0]  r_typ_wr;
  logic [PTR_W-1:0]  r_typ_rd;
  logic [DATA_W-1:0] r_rsp_mem [DEPTH];
  logic [PTR_W-1:0]  r_rsp_wr;
  logic [PTR_W-1:0]  r_rsp_rd;

  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wen;

  logic              w_cmd_hs;
  logic              w_consume;
  logic              w_rsp_ok;
  logic              w_rsp_push;
  logic              w_rsp_pop;
  logic              w_rsp_valid;
  logic              w_empty;
  logic              w_open;
  logic [CNT_W:0]    w_credit;

  assign w_rsp_valid = (r_rsp_cnt != '0);
  assign w_credit    = {1'b0, r_outs} + {1'b0, r_rsp_cnt};
  assign w_open      = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
  // Gated by reset_n so the port reads not-ready while reset is held.
  assign cmd_ready   = reset_n && w_open && !drain && !mem_freeze && (w_credit < DEPTH_C);

  assign w_cmd_hs    = cmd_valid && cmd_ready;
  assign w_consume   = r_mem_valid && !mem_freeze;
  assign w_rsp_ok    = mem_rvalid && (r_outs != '0);
  assign w_rsp_push  = w_rsp_ok && !r_typ[r_typ_rd];
  assign w_rsp_pop   = w_rsp_valid && rsp_ready;
  assign w_empty     = (r_outs == '0) && (r_rsp_cnt == '0);

  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_wen     = r_mem_wen;
  assign rsp_valid   = w_rsp_valid;
  assign rsp_data    = w_rsp_valid ? r_rsp_mem[r_rsp_rd] : '0;
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (drain) begin
      w_state_nxt = ST_DRAIN;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_cmd_hs) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (r_mem_valid && mem_freeze)
            w_state_nxt = ST_STALL;
          // A command accepted on this same edge keeps the machine active.
          else if (w_empty && !r_mem_valid && !w_cmd_hs)
            w_state_nxt = ST_IDLE;
        end
        ST_STALL:  if (!mem_freeze) w_state_nxt = ST_ACTIVE;
        ST_DRAIN:  if (w_empty) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Request register toward memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_wen   <= 1'b0;
    end else if (w_cmd_hs) begin
      r_mem_valid <= 1'b1;
      r_mem_addr  <= cmd_addr;
      r_mem_data  <= cmd_wdata;
      r_mem_wen   <= cmd_wen;
    end else if (w_consume) begin
      r_mem_valid <= 1'b0;
    end
  end

  // Outstanding counter and request-type FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outs   <= '0;
      r_typ    <= '0;
      r_typ_wr <= '0;
      r_typ_rd <= '0;
    end else begin
      case ({w_cmd_hs, w_rsp_ok})
        2'b10:   r_outs <= r_outs + CNT_W'(1);
        2'b01:   r_outs <= r_outs - CNT_W'(1);
        default: r_outs <= r_outs;
      endcase
      if (w_cmd_hs) begin
        r_typ[r_typ_wr] <= cmd_wen;
        r_typ_wr        <= r_typ_wr + PTR_W'(1);
      end
      if (w_rsp_ok) r_typ_rd <= r_typ_rd + PTR_W'(1);
    end
  end

  // Response FIFO control.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_cnt <= '0;
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
    end else begin
      if (w_rsp_push) r_rsp_wr <= r_rsp_wr + PTR_W'(1);
      if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + PTR_W'(1);
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
        2'b01:   r_rsp_cnt <= r_rsp_cnt - CNT_W'(1);
        default: r_rsp_cnt <= r_rsp_cnt;
      endcase
    end
  end

  // Response storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_rsp_push) r_rsp_mem[r_rsp_wr] <= mem_rdata;
  end

`ifdef MEM_INIT_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!reset_n)                         r_err <= 1'b0;
    else if (mem_rvalid && r_outs == '0)  r_err <= 1'b1;
  end
  assign err_unexpected = r_err;
`else
  assign err_unexpected = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_initiator.sv
// Testbench for mem_port_initiator: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_mem_port_initiator;
  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int DEP = 4;

  localparam int S_IDLE  = 0;
  localparam int S_ACT   = 1;
  localparam int S_STALL = 2;
  localparam int S_DRAIN = 3;

`ifdef MEM_INIT_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, cmd_valid, cmd_wen, drain, mem_freeze, mem_rvalid, rsp_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, mem_rdata;
  logic          cmd_ready, mem_wen, mem_valid, rsp_valid, busy, err_unexpected;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, rsp_data;

  always #5 clk = ~clk;

  mem_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wen(cmd_wen), .drain(drain),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wen(mem_wen), .mem_valid(mem_valid),
    .mem_freeze(mem_freeze), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain counters and queues.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            w;
  } req_t;

  int            m_st;
  int            m_outs;
  bit            m_mv;
  logic [AW-1:0] m_ma;
  logic [DW-1:0] m_md;
  bit            m_mw;
  bit            m_typ[$];
  logic [DW-1:0] m_rsp[$];
  bit            m_err;
  req_t          pend[$];

  function automatic bit exp_ready();
    return (reset_n === 1'b1) && (m_st == S_IDLE || m_st == S_ACT) && !drain && !mem_freeze
           && (m_outs + int'(m_rsp.size()) < DEP);
  endfunction

  task automatic model_step();
    bit hs, cons, rv_ok, pop, empty_now, w;
    if (!reset_n) begin
      m_st = S_IDLE; m_outs = 0; m_mv = 0; m_ma = '0; m_md = '0; m_mw = 0;
      m_typ.delete(); m_rsp.delete(); m_err = 0; pend.delete();
      return;
    end
    hs        = cmd_valid && exp_ready();
    cons      = m_mv && !mem_freeze;
    rv_ok     = mem_rvalid && (m_outs > 0);
    pop       = (m_rsp.size() > 0) && rsp_ready;
    empty_now = (m_outs == 0) && (m_rsp.size() == 0);
    if (mem_rvalid && m_outs == 0 && EXP_ERR) m_err = 1;
    if (drain) m_st = S_DRAIN;
    else case (m_st)
      S_IDLE:  if (hs) m_st = S_ACT;
      S_ACT:   if (m_mv && mem_freeze) m_st = S_STALL;
               else if (empty_now && !m_mv && !hs) m_st = S_IDLE;
      S_STALL: if (!mem_freeze) m_st = S_ACT;
      default: if (empty_now) m_st = S_IDLE;
    endcase
    if (cons) pend.push_back(req_t'{m_ma, m_md, m_mw});
    if (pop) void'(m_rsp.pop_front());
    if (rv_ok) begin
      w = m_typ.pop_front();
      if (!w) m_rsp.push_back(mem_rdata);
    end
    if (hs) begin
      m_typ.push_back(cmd_wen);
      m_mv = 1; m_ma = cmd_addr; m_md = cmd_wdata; m_mw = cmd_wen;
    end else if (cons) begin
      m_mv = 0;
    end
    m_outs += int'(hs) - int'(rv_ok);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready()));
      check("mem_valid", 32'(mem_valid), 32'(m_mv));
      check("mem_addr",  32'(mem_addr),  32'(m_ma));
      check("mem_data",  32'(mem_data),  32'(m_md));
      check("mem_wen",   32'(mem_wen),   32'(m_mw));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rsp.size() > 0));
      if (m_rsp.size() > 0) check("rsp_data", 32'(rsp_data), 32'(m_rsp[0]));
      check("busy",      32'(busy),      32'(m_st != S_IDLE));
      check("err_unexpected", 32'(err_unexpected), 32'(m_err));
    end
  end

  task automatic quiet();
    cmd_valid = 0; cmd_wen = 0; cmd_addr = '0; cmd_wdata = '0;
    drain = 0; mem_freeze = 0; mem_rvalid = 0; mem_rdata = '0; rsp_ready = 0;
  endtask

  task automatic respond(input logic [DW-1:0] d);
    mem_rvalid = 1; mem_rdata = d;
    tick();
    mem_rvalid = 0;
  endtask

  initial begin
    req_t r;
    reset_n = 0;
    quiet();
    tick(); tick();
    chk_en = 1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_err",       32'(err_unexpected), 32'h0);
    reset_n = 1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'h1);

    // Single read 0x123 returning 0xBEEF.
    cmd_valid = 1; cmd_addr = 12'h123; cmd_wen = 0;
    tick();
    cmd_valid = 0;
    check("rd_mem_valid", 32'(mem_valid), 32'h1);
    check("rd_mem_addr",  32'(mem_addr),  32'h123);
    check("rd_mem_wen",   32'(mem_wen),   32'h0);
    tick();
    check("rd_consumed", 32'(mem_valid), 32'h0);
    respond(16'hBEEF);
    check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_rsp_data",  32'(rsp_data),  32'hBEEF);
    rsp_ready = 1; tick(); rsp_ready = 0;
    check("rd_popped", 32'(rsp_valid), 32'h0);
    tick();
    check("rd_idle", 32'(busy), 32'h0);

    // Freeze for three cycles while a write is presented.
    cmd_valid = 1; cmd_addr = 12'h3C5; cmd_wdata = 16'hA5A5; cmd_wen = 1;
    tick();
    cmd_addr = 12'h111; cmd_wen = 0; mem_freeze = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_valid", 32'(mem_valid), 32'h1);
      check("frz_addr",  32'(mem_addr),  32'h3C5);
      check("frz_data",  32'(mem_data),  32'hA5A5);
      check("frz_ready", 32'(cmd_ready), 32'h0);
    end
    mem_freeze = 0; #1;
    check("stall_ready", 32'(cmd_ready), 32'h0);
    cmd_valid = 0;
    tick();
    check("frz_consumed", 32'(mem_valid), 32'h0);
    respond(16'h7777);
    check("wr_rsp_dropped", 32'(rsp_valid), 32'h0);
    tick();

    // Credit limit: four reads, no pops.
    cmd_valid = 1; cmd_wen = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_addr = AW'(12'h200 + i);
      tick();
    end
    cmd_valid = 0;
    check("full_ready", 32'(cmd_ready), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) respond(DW'(16'h1000 + i));
    check("fifo_full_ready", 32'(cmd_ready), 32'h0);
    check("fifo_head",       32'(rsp_data),  32'h1000);
    rsp_ready = 1; tick(); rsp_ready = 0;
    check("fifo_next",     32'(rsp_data),  32'h1001);
    check("credit_return", 32'(cmd_ready), 32'h1);
    rsp_ready = 1; tick(); tick(); tick(); rsp_ready = 0;
    check("fifo_drained", 32'(rsp_valid), 32'h0);
    tick();

    // Write then read of the same address.
    cmd_valid = 1; cmd_addr = 12'h0AA; cmd_wdata = 16'h5555; cmd_wen = 1;
    tick();
    cmd_wen = 0;
    tick();
    cmd_valid = 0;
    tick();
    respond(16'hDEAD);
    check("wr_drop", 32'(rsp_valid), 32'h0);
    respond(16'h5555);
    check("wr_rd_valid", 32'(rsp_valid), 32'h1);
    check("wr_rd_data",  32'(rsp_data),  32'h5555);
    rsp_ready = 1; tick(); rsp_ready = 0;
    check("wr_rd_single", 32'(rsp_valid), 32'h0);
    tick();

    // Drain with two outstanding reads, then a stray response.
    cmd_valid = 1; cmd_wen = 0; cmd_addr = 12'h300;
    tick();
    cmd_addr = 12'h301;
    tick();
    cmd_valid = 0; drain = 1;
    tick();
    cmd_valid = 1; #1;
    check("drn_ready", 32'(cmd_ready), 32'h0);
    check("drn_busy",  32'(busy),      32'h1);
    respond(16'h0300);
    respond(16'h0301);
    check("drn_busy2", 32'(busy), 32'h1);
    rsp_ready = 1; tick(); tick(); rsp_ready = 0;
    check("drn_empty", 32'(rsp_valid), 32'h0);
    cmd_valid = 0; drain = 0;
    tick();
    check("drn_idle", 32'(busy), 32'h0);
    respond(16'hFFFF);
    check("stray_err", 32'(err_unexpected), 32'(EXP_ERR));
    tick();

    reset_n = 0; tick(); tick(); reset_n = 1;
    check("err_cleared", 32'(err_unexpected), 32'h0);
    tick();

    // Randomized traffic, including a mid-run reset and drain windows.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_n    = !(cyc >= 1500 && cyc < 1502);
      drain      = ((cyc % 400) >= 320) && ((cyc % 400) < 360);
      mem_freeze = ($urandom_range(0, 3) == 0);
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_addr   = AW'($urandom);
      cmd_wdata  = DW'($urandom);
      cmd_wen    = ($urandom_range(0, 1) == 1);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      mem_rvalid = 0;
      mem_rdata  = DW'($urandom);
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        r = pend.pop_front();
        mem_rvalid = 1;
      end else if (pend.size() == 0 && m_outs == 0 && $urandom_range(0, 60) == 0) begin
        mem_rvalid = 1;
      end
      tick();
    end

    quiet();
    rsp_ready = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_rvalid = 0;
      if (pend.size() > 0) begin
        r = pend.pop_front();
        mem_rvalid = 1;
        mem_rdata = DW'($urandom);
      end
      tick();
    end
    check("final_idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
